// File: rtl/fma16_pkg.sv
// fma16_pkg
//  Shared constants and types for the fma16 datapath.
//  NF      : fraction bits of a half-precision operand (significand = NF+1 bits)
//  BIAS    : exponent bias of the half-precision format
//  ALIGN_W : width of the aligned addend / sum field, shared with the normalizer
//  EW      : width of the signed internal exponent
//  Helper functions compute the product exponent and the addend alignment count.
package fma16_pkg;

    localparam int NF      = 10;
    localparam int BIAS    = 15;
    localparam int ALIGN_W = 3 * (NF + 1) + 3;
    localparam int EW      = 7;
    localparam int XW      = 5;
    localparam int SHW     = $clog2(ALIGN_W + 1);

    typedef logic signed [EW-1:0] exp_t;
    typedef logic signed [EW:0]   cnt_t;
    typedef logic [ALIGN_W-1:0]   align_t;
    typedef logic [SHW-1:0]       shamt_t;
    typedef logic [NF:0]          sig_t;
    typedef logic [XW-1:0]        bexp_t;

    // Xe+Ye-BIAS; with 5-bit biased inputs the result spans -15..47 and fits EW bits.
    function automatic exp_t product_exp(input bexp_t xe, input bexp_t ye);
        return exp_t'({2'b00, xe}) + exp_t'({2'b00, ye}) - exp_t'(BIAS);
    endfunction

    // Pe-Ze+(NF+2) in EW+1 bits; spans -34..59, so it can never overflow.
    function automatic cnt_t align_count(input exp_t pe, input bexp_t ze);
        return cnt_t'(pe) - cnt_t'({1'b0, ze}) + cnt_t'(NF + 2);
    endfunction

endpackage

// File: rtl/fma16_rshift_sticky.sv
// fma16_rshift_sticky
//  Combinational barrel right shift of an ALIGN_W-bit field with sticky collection.
//  din    in   ALIGN_W  value to shift
//  shift  in   SHW      right-shift amount (ALIGN_W or more clears dout entirely)
//  dout   out  ALIGN_W  din >> shift
//  sticky out  1        OR of every bit shifted past bit 0
module fma16_rshift_sticky
    import fma16_pkg::*;
(
    input  align_t din,
    input  shamt_t shift,
    output align_t dout,
    output logic   sticky
);

    logic [2*ALIGN_W-1:0] wide;

    // Shifting inside a double-width field keeps the shifted-out bits in the
    // lower half, so the sticky bit is simply the OR of that half.
    always_comb begin
        wide   = {din, {ALIGN_W{1'b0}}} >> shift;
        dout   = wide[2*ALIGN_W-1:ALIGN_W];
        sticky = |wide[ALIGN_W-1:0];
    end

endmodule

// File: rtl/fma16_addend_align.sv
// fma16_addend_align
//  Addend alignment stage of the fma16 datapath. Right-shifts the addend
//  significand into the ALIGN_W-bit sum field relative to the product exponent,
//  gathers shifted-out bits into a sticky bit and flags the product-kill and
//  addend-kill cases. Two-stage valid/ready pipeline with a whole-pipe stall.
//  clk       in   1        rising-edge clock
//  reset_n   in   1        synchronous reset, active low
//  in_valid  in   1        input beat present
//  in_ready  out  1        stage can accept an input beat
//  Xe, Ye    in   5        biased exponents of the multiplicands
//  Ze        in   5        effective biased exponent of the addend
//  Zm        in   NF+1     addend significand, hidden bit included
//  out_valid out  1        aligned beat present
//  out_ready in   1        consumer accepts the beat
//  Pe        out  EW       product exponent, signed
//  Am        out  ALIGN_W  aligned addend
//  ASticky   out  1        OR of addend bits shifted out of Am
//  KillProd  out  1        addend exponent dominates the product
//  KillZ     out  1        addend lies entirely below Am
module fma16_addend_align
    import fma16_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  bexp_t  Xe,
    input  bexp_t  Ye,
    input  bexp_t  Ze,
    input  sig_t   Zm,
    output logic   out_valid,
    input  logic   out_ready,
    output exp_t   Pe,
    output align_t Am,
    output logic   ASticky,
    output logic   KillProd,
    output logic   KillZ
);

    exp_t   pe_c;
    cnt_t   acnt_c;
    shamt_t shift_c;
    logic   kill_prod_c;
    logic   kill_z_c;

    logic   s1_valid;
    exp_t   s1_pe;
    sig_t   s1_zm;
    shamt_t s1_shift;
    logic   s1_kill_prod;
    logic   s1_kill_z;

    align_t sh_out;
    logic   sh_sticky;

    // The whole pipe advances together; only a full, blocked output stalls it.
    assign in_ready = !out_valid || out_ready;

    // A negative count means the addend sits above the product: no shift.
    // A count past the field saturates to ALIGN_W so the shifter clears Am and
    // folds the entire significand into the sticky bit.
    always_comb begin
        pe_c        = product_exp(Xe, Ye);
        acnt_c      = align_count(pe_c, Ze);
        kill_prod_c = acnt_c < cnt_t'(0);
        kill_z_c    = acnt_c > cnt_t'(ALIGN_W - 1);
        if (kill_prod_c) begin
            shift_c = '0;
        end else if (kill_z_c) begin
            shift_c = shamt_t'(ALIGN_W);
        end else begin
            shift_c = acnt_c[SHW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_pe        <= '0;
            s1_zm        <= '0;
            s1_shift     <= '0;
            s1_kill_prod <= 1'b0;
            s1_kill_z    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pe        <= pe_c;
                s1_zm        <= Zm;
                s1_shift     <= shift_c;
                s1_kill_prod <= kill_prod_c;
                s1_kill_z    <= kill_z_c;
            end
        end
    end

    fma16_rshift_sticky u_rshift (
        .din    ({s1_zm, {(ALIGN_W - NF - 1){1'b0}}}),
        .shift  (s1_shift),
        .dout   (sh_out),
        .sticky (sh_sticky)
    );

    // Output data only loads with a real beat, so a stalled beat holds steady.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            Pe        <= '0;
            Am        <= '0;
            ASticky   <= 1'b0;
            KillProd  <= 1'b0;
            KillZ     <= 1'b0;
        end else if (in_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Pe       <= s1_pe;
                Am       <= sh_out;
                ASticky  <= sh_sticky;
                KillProd <= s1_kill_prod;
                KillZ    <= s1_kill_z;
            end
        end
    end

endmodule

// File: tb/tb_fma16_addend_align.sv
// tb_fma16_addend_align
//  Scoreboard bench for fma16_addend_align: the driver pushes hand-computed
//  expected results when a beat is accepted; an independent monitor pops and
//  compares whenever the DUT hands a beat to the consumer.
module tb_fma16_addend_align;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  Xe;
    logic [4:0]  Ye;
    logic [4:0]  Ze;
    logic [10:0] Zm;
    logic        out_valid;
    logic        out_ready;
    logic signed [6:0] Pe;
    logic [35:0] Am;
    logic        ASticky;
    logic        KillProd;
    logic        KillZ;

    typedef struct {
        logic [6:0]  pe;
        logic [35:0] am;
        logic        st;
        logic        kp;
        logic        kz;
    } exp_s;

    exp_s sb[$];
    int   total = 0;
    int   bad   = 0;

    fma16_addend_align dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xe        (Xe),
        .Ye        (Ye),
        .Ze        (Ze),
        .Zm        (Zm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Pe        (Pe),
        .Am        (Am),
        .ASticky   (ASticky),
        .KillProd  (KillProd),
        .KillZ     (KillZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [4:0] xe, input logic [4:0] ye, input logic [4:0] ze,
                                 input logic [10:0] zm, input logic [6:0] pe, input logic [35:0] am,
                                 input logic st, input logic kp, input logic kz);
        bit   accepted;
        exp_s e;
        accepted = 0;
        Xe = xe;
        Ye = ye;
        Ze = ze;
        Zm = zm;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.pe = pe;
                e.am = am;
                e.st = st;
                e.kp = kp;
                e.kz = kz;
                sb.push_back(e);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) reportFail("accept_timeout");
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) reportFail("drain_timeout");
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        checkOutput({tag, "_pe"},        {57'b0, Pe},        64'd0);
        checkOutput({tag, "_am"},        {28'b0, Am},        64'd0);
        checkOutput({tag, "_asticky"},   {63'b0, ASticky},   64'd0);
        checkOutput({tag, "_killprod"},  {63'b0, KillProd},  64'd0);
        checkOutput({tag, "_killz"},     {63'b0, KillZ},     64'd0);
    endtask

    // Monitor: while a beat is held it must already match the queue head;
    // it leaves the queue only when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                if (sb.size() == 0) begin
                    if (out_ready) reportFail("unexpected_beat");
                end else begin
                    checkOutput("pe",       {57'b0, Pe},       {57'b0, sb[0].pe});
                    checkOutput("am",       {28'b0, Am},       {28'b0, sb[0].am});
                    checkOutput("asticky",  {63'b0, ASticky},  {63'b0, sb[0].st});
                    checkOutput("killprod", {63'b0, KillProd}, {63'b0, sb[0].kp});
                    checkOutput("killz",    {63'b0, KillZ},    {63'b0, sb[0].kz});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Xe = '0;
        Ye = '0;
        Ze = '0;
        Zm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // First beat with explicit two-cycle latency: still in stage 1 after
        // the accepting edge, visible after the following one.
        applyStimulus(5'd15, 5'd15, 5'd15, 11'h400, 7'd15, 36'h000800000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lat_stage1_out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("lat_stage2_out_valid", {63'b0, out_valid}, 64'd1);
        waitDrain();

        // Back-to-back directed vectors, including both kill boundaries.
        applyStimulus(5'd25, 5'd23, 5'd15, 11'h401, 7'd33, 36'h000000020, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd15, 5'd15, 5'd30, 11'h400, 7'd15, 36'h800000000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd30, 5'd30, 5'd1,  11'h7FF, 7'd45, 36'h000000000, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'd30, 5'd30, 5'd1,  11'h000, 7'd45, 36'h000000000, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd9,  5'd9,  5'd15, 11'h555, 7'd3,  36'hAAA000000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd9,  5'd9,  5'd16, 11'h555, 7'd3,  36'hAAA000000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd30, 5'd20, 5'd12, 11'h7FF, 7'd35, 36'h000000001, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd30, 5'd20, 5'd11, 11'h7FF, 7'd35, 36'h000000000, 1'b1, 1'b0, 1'b1);
        // Pe = -15 is 7'h71 in two's complement.
        applyStimulus(5'd0,  5'd0,  5'd1,  11'h3FF, 7'h71, 36'h7FE000000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'd15, 5'd15, 5'd15, 11'h000, 7'd15, 36'h000000000, 1'b0, 1'b0, 1'b0);
        waitDrain();

        // Stall: four back-to-back beats while the consumer refuses the first
        // three cycles of output.
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(5'd15, 5'd15, 5'd15, 11'h400, 7'd15, 36'h000800000, 1'b0, 1'b0, 1'b0);
                applyStimulus(5'd25, 5'd23, 5'd15, 11'h401, 7'd33, 36'h000000020, 1'b1, 1'b0, 1'b0);
                applyStimulus(5'd30, 5'd20, 5'd12, 11'h7FF, 7'd35, 36'h000000001, 1'b1, 1'b0, 1'b0);
                applyStimulus(5'd9,  5'd9,  5'd15, 11'h555, 7'd3,  36'hAAA000000, 1'b0, 1'b0, 1'b0);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                if (!seen) reportFail("stall_out_valid_timeout");
                checkOutput("stall_in_ready_c0", {63'b0, in_ready}, 64'd0);
                @(negedge clk);
                checkOutput("stall_in_ready_c1", {63'b0, in_ready}, 64'd0);
                @(negedge clk);
                checkOutput("stall_in_ready_c2", {63'b0, in_ready}, 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall_queue_empty", 64'(sb.size()), 64'd0);

        // Reset with two beats in flight: both are discarded.
        applyStimulus(5'd15, 5'd15, 5'd15, 11'h400, 7'd15, 36'h000800000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd25, 5'd23, 5'd15, 11'h401, 7'd33, 36'h000000020, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("midreset");
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(5'd15, 5'd15, 5'd30, 11'h400, 7'd15, 36'h800000000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_stage1_out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("post_reset_stage2_out_valid", {63'b0, out_valid}, 64'd1);
        waitDrain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
